// File: rtl/dma_stream_reader_if.sv
// Bus bundle for the DMA stream reader: the data-memory read port and the
// valid/ready output stream. The reader drives it through the master modport;
// the memory/consumer side uses the slave modport.
interface dma_stream_reader_if #(
    parameter int N  = 32,
    parameter int AW = 19
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_last;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/dma_stream_reader.sv
// DMA stream reader: on a rising edge of the go bit in the command word, reads
// len consecutive words starting at src from a 1-cycle-latency data memory and
// presents them as a valid/ready stream through a 2-entry FIFO.
// cmd layout: [N-1] go, [N-2 -: LW] length in words, [AW-1:0] source address.
module dma_stream_reader #(
    parameter int N  = 32,
    parameter int AW = 19,
    parameter int LW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        cmd,
    dma_stream_reader_if.master bus,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LW-1:0] LW_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LW_ONE  = {{(LW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_go;
    logic [LW-1:0] r_len;
    logic [AW-1:0] r_src;
    logic [LW-1:0] r_issued;
    logic [LW-1:0] r_accepted;
    logic          r_inflight;

    logic [N-1:0]  r_fifo [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic [LW-1:0] w_cmd_len;
    logic [AW-1:0] w_cmd_src;
    logic          w_start;
    logic          w_take;
    logic          w_fifo_ne;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_occ;
    logic          w_credit;
    logic          w_issue;
    logic          w_last_head;
    logic          w_last_pop;

    assign w_cmd_len = cmd[N-2 -: LW];
    assign w_cmd_src = cmd[AW-1:0];

    // Start is the 0->1 edge of go; a held go produces no further starts.
    assign w_start   = cmd[N-1] & ~r_go;
    assign w_take    = (r_state == S_IDLE) && w_start;

    assign w_fifo_ne = (r_count != 2'd0);
    assign w_pop     = w_fifo_ne && bus.out_ready;
    // A request issued last cycle returns its data now.
    assign w_push    = r_inflight;

    // Slots already claimed: stored words plus the word returning this cycle.
    // A word leaving this cycle frees its slot before the new request's data
    // can land (two edges later), which keeps the stream at one word per cycle
    // without ever exceeding two entries.
    assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_credit  = (w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop);
    assign w_issue   = (r_state == S_RUN) && (r_issued < r_len) && w_credit;

    // Words leave in order, so the head's index equals the accepted count.
    assign w_last_head = w_fifo_ne && (r_accepted == (r_len - LW_ONE));
    assign w_last_pop  = w_pop && w_last_head;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN (or DONE for zero length) -> DRAIN -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_cmd_len == LW_ZERO) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_issued == r_len) begin
                    if (w_last_pop) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Go-edge history, command capture and issue/accept counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_go       <= 1'b0;
            r_len      <= LW_ZERO;
            r_src      <= {AW{1'b0}};
            r_issued   <= LW_ZERO;
            r_accepted <= LW_ZERO;
            r_inflight <= 1'b0;
        end else begin
            r_go       <= cmd[N-1];
            r_inflight <= w_issue;
            if (w_take) begin
                r_len      <= w_cmd_len;
                r_src      <= w_cmd_src;
                r_issued   <= LW_ZERO;
                r_accepted <= LW_ZERO;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + LW_ONE;
                end else begin
                    r_issued <= r_issued;
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + LW_ONE;
                end else begin
                    r_accepted <= r_accepted;
                end
            end
        end
    end

    // Two-entry FIFO: pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture returning read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fifo[0] <= {N{1'b0}};
            r_fifo[1] <= {N{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= bus.mem_rdata;
            end else begin
                r_fifo[r_wptr] <= r_fifo[r_wptr];
            end
        end
    end

    // Address wraps modulo 2^AW; it reads as zero when no request is made.
    assign bus.mem_rd_en = w_issue;
    assign bus.mem_addr  = w_issue ? (r_src + AW'(r_issued)) : {AW{1'b0}};
    assign bus.out_valid = w_fifo_ne;
    assign bus.out_data  = w_fifo_ne ? r_fifo[r_rptr] : {N{1'b0}};
    assign bus.out_last  = w_last_head;
    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_dma_stream_reader.sv
// Self-checking bench for dma_stream_reader: a table of directed transfers,
// randomized transfers with random backpressure checked against a queue-based
// reference model, and hand-written held-go, retrigger and mid-run reset cases.
module tb_dma_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        busy;
    logic        done;

    dma_stream_reader_if #(.N(32), .AW(19)) bus ();

    dma_stream_reader #(.N(32), .AW(19), .LW(12)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] salt;

    // Outputs sampled mid-cycle (negedge) by cycle().
    logic        s_rd, s_valid, s_last, s_busy, s_done, s_ready;
    logic [18:0] s_addr;
    logic [31:0] s_data;

    typedef struct {
        logic [18:0] src;
        logic [11:0] len;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_done;
    } vec_t;

    vec_t vecs [5];

    // Memory contents: word at address a.
    function automatic logic [31:0] mem_word(input logic [18:0] a);
        return salt ^ {13'd0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample this cycle's outputs, then advance past the edge and return the
    // memory data for any read requested in the sampled cycle.
    task automatic cycle();
        @(negedge clk);
        s_rd    = bus.mem_rd_en;
        s_addr  = bus.mem_addr;
        s_valid = bus.out_valid;
        s_data  = bus.out_data;
        s_last  = bus.out_last;
        s_ready = bus.out_ready;
        s_busy  = busy;
        s_done  = done;
        @(posedge clk);
        #1;
        if (s_rd) bus.mem_rdata = mem_word(s_addr);
        else      bus.mem_rdata = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"},    s_rd,    1'b0);
        chk({tag, "_addr"},  s_addr,  19'h0);
        chk({tag, "_valid"}, s_valid, 1'b0);
        chk({tag, "_data"},  s_data,  32'h0);
        chk({tag, "_last"},  s_last,  1'b0);
        chk({tag, "_busy"},  s_busy,  1'b0);
        chk({tag, "_done"},  s_done,  1'b0);
    endtask

    // One transfer checked against the model: expected addresses and words in
    // order, last flag on index len-1, head stable while stalled, at most two
    // words requested but not yet accepted, busy while words remain, done in
    // the cycle after the last acceptance. Cycle 0 is the cycle go is raised.
    // rmode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,...
    task automatic run_xfer(input logic [18:0] src, input logic [11:0] len, input int rmode,
                            input bit hold_go, input bit retrig,
                            output logic [31:0] first_d, output logic [31:0] last_d,
                            output int done_cyc, output int first_v_cyc, output int nwords);
        logic [31:0] expq [$];
        logic [18:0] addrq [$];
        int          issued_n;
        int          acc_n;
        int          acc_before;
        bit          prev_stall;
        logic [31:0] prev_data;
        bit          fin;
        bit          exp_busy;
        bit          exp_done;
        first_d = 32'h0; last_d = 32'h0; done_cyc = -1; first_v_cyc = -1; nwords = 0;
        issued_n = 0; acc_n = 0; prev_stall = 1'b0; prev_data = 32'h0; fin = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            addrq.push_back(src + 19'(i));
            expq.push_back(mem_word(src + 19'(i)));
        end
        cmd = 32'h0;
        bus.out_ready = 1'b1;
        cycle();
        cmd = {1'b1, len, src};
        for (int c = 0; c < 4 * int'(len) + 40 && !fin; c++) begin
            if (c > 0 && !hold_go) cmd[31] = 1'b0;
            if (retrig && c == 2) cmd = {1'b1, 12'd9, 19'h33333};
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = ((c % 3) == 0);
            endcase
            cycle();
            acc_before = acc_n;
            exp_busy = (len != 12'd0) && (c >= 1) && (acc_before < int'(len));
            exp_done = (len == 12'd0) ? (c == 1) : (acc_before == int'(len));
            chk("busy", s_busy, exp_busy);
            chk("done", s_done, exp_done);
            if (s_done) done_cyc = c;
            if (exp_done || s_done) fin = 1'b1;
            if (s_rd) begin
                issued_n++;
                if (addrq.size() > 0) chk("mem_addr", s_addr, addrq.pop_front());
                else                  chk("extra_rd", s_rd, 1'b0);
            end
            if (prev_stall) begin
                chk("stall_valid", s_valid, 1'b1);
                chk("stall_data", s_data, prev_data);
            end
            if (s_valid) begin
                if (first_v_cyc < 0) first_v_cyc = c;
                chk("out_last", s_last, (acc_n == int'(len) - 1));
                if (s_ready) begin
                    if (expq.size() > 0) chk("out_data", s_data, expq.pop_front());
                    else                 chk("extra_word", s_valid, 1'b0);
                    if (acc_n == 0) first_d = s_data;
                    last_d = s_data;
                    acc_n++;
                end
            end else begin
                chk("last_idle", s_last, 1'b0);
            end
            chk("credit", ((issued_n - acc_n) <= 2), 1'b1);
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
        end
        nwords = acc_n;
        if (!fin) begin
            chk("timeout", fin, 1'b1);
        end else begin
            cycle();
            chk("done_pulse", s_done, 1'b0);
            chk("busy_after", s_busy, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] fd, ld;
        int          dc, fv, nw, acc;
        logic [18:0] rsrc;
        logic [11:0] rlen;

        salt = 32'h0;
        rst = 1'b0;
        cmd = 32'h0;
        bus.out_ready = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset state.
        cycle();
        cycle();
        chk_all_zero("reset");
        rst = 1'b1;

        // Directed table, ready held high; word[a] = a.
        vecs[0] = '{19'h00100, 12'd4, 32'h00000100, 32'h00000103, 7};
        vecs[1] = '{19'h7FFFE, 12'd3, 32'h0007FFFE, 32'h00000000, 6};
        vecs[2] = '{19'h00000, 12'd0, 32'h00000000, 32'h00000000, 1};
        vecs[3] = '{19'h12345, 12'd1, 32'h00012345, 32'h00012345, 4};
        vecs[4] = '{19'h00010, 12'd8, 32'h00000010, 32'h00000017, 11};
        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].src, vecs[i].len, 0, 1'b0, 1'b0, fd, ld, dc, fv, nw);
            chk("tbl_done_cyc", dc, vecs[i].exp_done);
            chk("tbl_nwords", nw, int'(vecs[i].len));
            if (vecs[i].len != 12'd0) begin
                chk("tbl_first", fd, vecs[i].exp_first);
                chk("tbl_last", ld, vecs[i].exp_last);
                chk("tbl_latency", fv, 3);
            end
        end

        // Backpressure with ready 1,0,0,...
        run_xfer(19'h00300, 12'd5, 2, 1'b0, 1'b0, fd, ld, dc, fv, nw);
        chk("bp_nwords", nw, 5);
        chk("bp_last", ld, 32'h00000304);

        // Go held through completion: exactly one transfer.
        run_xfer(19'h00040, 12'd4, 0, 1'b1, 1'b0, fd, ld, dc, fv, nw);
        chk("hold_done_cyc", dc, 7);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_busy", s_busy, 1'b0);
            chk("hold_rd", s_rd, 1'b0);
            chk("hold_valid", s_valid, 1'b0);
        end
        cmd = 32'h0;

        // Second go edge during RUN is ignored.
        run_xfer(19'h00080, 12'd4, 0, 1'b0, 1'b1, fd, ld, dc, fv, nw);
        chk("retrig_done_cyc", dc, 7);
        chk("retrig_nwords", nw, 4);

        // Randomized transfers against the model.
        salt = $urandom;
        for (int k = 0; k < 12; k++) begin
            if ((k % 3) == 0) rsrc = 19'h7FFFF - 19'($urandom_range(0, 4));
            else              rsrc = 19'($urandom_range(0, 32'h7FFFF));
            rlen = 12'($urandom_range(1, 20));
            run_xfer(rsrc, rlen, 1, 1'b0, 1'b0, fd, ld, dc, fv, nw);
            chk("rand_nwords", nw, int'(rlen));
        end
        salt = 32'h0;

        // Reset after two of six words accepted.
        cmd = 32'h0;
        bus.out_ready = 1'b1;
        cycle();
        cmd = {1'b1, 12'd6, 19'h00200};
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            if (c > 0) cmd[31] = 1'b0;
            cycle();
            if (s_valid && s_ready) acc++;
        end
        chk("rst_pre_acc", acc, 2);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk_all_zero("rst_mid");
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rst_stray_valid", s_valid, 1'b0);
            chk("rst_stray_rd", s_rd, 1'b0);
            chk("rst_stray_busy", s_busy, 1'b0);
        end
        run_xfer(19'h00200, 12'd6, 0, 1'b0, 1'b0, fd, ld, dc, fv, nw);
        chk("post_rst_nwords", nw, 6);
        chk("post_rst_first", fd, 32'h00000200);
        chk("post_rst_done_cyc", dc, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
